// File: rtl/lock_pkg.sv
// Shared definitions for the canal lock sequencer.
//
// Contents:
//   state_t           controller states (9 states, 4-bit encoding)
//   PORT_CLOSED       value of a port-status input when that port is shut
//   OUTER_LEVEL,
//   INNER_LEVEL,
//   LOCK_RESET_LEVEL  nominal water levels used by the bench datapath
//   side_sel          picks the outer or inner flavour of a signal by direction
package lock_pkg;

  typedef enum logic [3:0] {
    IDLE,
    EQ_ENTRY,
    OPEN_ENTRY,
    ENTER,
    CLOSE_ENTRY,
    EQ_EXIT,
    OPEN_EXIT,
    EXIT,
    CLOSE_EXIT
  } state_t;

  localparam logic       PORT_CLOSED      = 1'b1;
  localparam logic [7:0] OUTER_LEVEL      = 8'd73;
  localparam logic [7:0] INNER_LEVEL      = 8'd49;
  localparam logic [7:0] LOCK_RESET_LEVEL = 8'd52;

  // dir=1 means the gondola enters from the outer side, so the outer
  // flavour of a signal belongs to the entry side.
  function automatic logic side_sel(input logic dir, input logic outer_v,
                                    input logic inner_v);
    return dir ? outer_v : inner_v;
  endfunction

endpackage

// File: rtl/water_window_cmp.sv
// Water level window comparator.
//
// Classifies the lock level against a target with a tolerance band of
// +/-TOL. The band edges saturate at 0 and 255 so the compare never wraps.
//
// Ports:
//   level   in  8  current lock level
//   target  in  8  level the lock is being equalized to
//   below   out 1  level is under the band (needs filling)
//   above   out 1  level is over the band (needs draining)
//   match   out 1  level is inside the band
module water_window_cmp #(
  parameter int TOL = 2
) (
  input  logic [7:0] level,
  input  logic [7:0] target,
  output logic       below,
  output logic       above,
  output logic       match
);

  localparam logic [7:0] TOL8 = 8'(TOL);

  logic [7:0] lo;
  logic [7:0] hi;

  // Saturating band edges: clamp instead of letting target-TOL underflow or
  // target+TOL overflow.
  always_comb begin
    lo = (target < TOL8) ? 8'd0 : target - TOL8;
    hi = (target > (8'd255 - TOL8)) ? 8'd255 : target + TOL8;
  end

  assign below = level < lo;
  assign above = level > hi;
  assign match = ~below & ~above;

endmodule

// File: rtl/lock_sequencer.sv
// Canal lock transit sequencer.
//
// Arbitrates gondolas waiting at the outer and inner sides, equalizes the
// lock to the entry side, opens/closes the entry port around the gondola,
// then repeats for the exit side. Every output is registered.
//
// Build option: define LOCK_SEQ_STATS_EN to add the transit/abort counters.
//
// Ports:
//   clk             in  1  clock, rising edge
//   rst             in  1  asynchronous reset, active low
//   req_outer/inner in  1  gondola waiting at that side (level)
//   lock_water      in  8  lock chamber level
//   outer/inner_water in 8 levels outside each port
//   outer/inner_closed in 1 port status, 1=closed
//   gondola_inside  in  1  gondola is in the chamber
//   fill, drain     out 1  level commands to the datapath
//   outer/inner_cmd out 1  1=close that port
//   grant_outer/inner out 1 gondola on that side may enter
//   depart_ok       out 1  gondola may leave through the exit port
//   transit_done    out 1  one-cycle pulse when a transit completes
//   fault           out 1  sticky equalize timeout
//   transit_count   out 16 completed transits, wrapping (stats build only)
//   abort_count     out 8  aborted entries, saturating (stats build only)
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int TOL           = 2,
  parameter int ENTER_TIMEOUT = 16,
  parameter int EQ_TIMEOUT    = 64,
  parameter int CW            = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_outer,
  input  logic        req_inner,
  input  logic [7:0]  lock_water,
  input  logic [7:0]  outer_water,
  input  logic [7:0]  inner_water,
  input  logic        outer_closed,
  input  logic        inner_closed,
  input  logic        gondola_inside,
  output logic        fill,
  output logic        drain,
  output logic        outer_cmd,
  output logic        inner_cmd,
  output logic        grant_outer,
  output logic        grant_inner,
  output logic        depart_ok,
  output logic        transit_done,
  output logic        fault
`ifdef LOCK_SEQ_STATS_EN
  ,
  output logic [15:0] transit_count,
  output logic [7:0]  abort_count
`endif
);

  localparam logic [CW-1:0] EQ_LAST    = CW'(EQ_TIMEOUT - 1);
  localparam logic [CW-1:0] ENTER_LAST = CW'(ENTER_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  state_t        state, state_next;
  logic          dir, dir_next;
  logic          last_outer, last_outer_next;
  logic          abort_flag, abort_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          fault_next, done_next;
  logic          fill_next, drain_next;
  logic          outer_cmd_next, inner_cmd_next;
  logic          entry_open_next, exit_open_next;

  logic       served_req, entry_closed, exit_closed, both_closed;
  logic [7:0] target;
  logic       below, above, match;

  assign served_req   = side_sel(dir, req_outer, req_inner);
  assign entry_closed = side_sel(dir, outer_closed, inner_closed);
  assign exit_closed  = side_sel(dir, inner_closed, outer_closed);
  assign both_closed  = outer_closed & inner_closed;

  // One comparator serves both equalize phases; the exit phase aims at the
  // side opposite the entry.
  assign target = (state == EQ_EXIT) ? (dir ? inner_water : outer_water)
                                     : (dir ? outer_water : inner_water);

  water_window_cmp #(.TOL(TOL)) u_window (
    .level  (lock_water),
    .target (target),
    .below  (below),
    .above  (above),
    .match  (match)
  );

  // State register plus every registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      dir          <= 1'b0;
      last_outer   <= 1'b0;
      abort_flag   <= 1'b0;
      cnt          <= '0;
      fill         <= 1'b0;
      drain        <= 1'b0;
      outer_cmd    <= 1'b1;
      inner_cmd    <= 1'b1;
      grant_outer  <= 1'b0;
      grant_inner  <= 1'b0;
      depart_ok    <= 1'b0;
      transit_done <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_next;
      dir          <= dir_next;
      last_outer   <= last_outer_next;
      abort_flag   <= abort_next;
      cnt          <= cnt_next;
      fill         <= fill_next;
      drain        <= drain_next;
      outer_cmd    <= outer_cmd_next;
      inner_cmd    <= inner_cmd_next;
      grant_outer  <= (state_next == ENTER) & dir_next;
      grant_inner  <= (state_next == ENTER) & ~dir_next;
      depart_ok    <= (state_next == EXIT);
      transit_done <= done_next;
      fault        <= fault_next;
    end
  end

  // Next-state logic. Outputs are derived from the state being entered so
  // that the registered values line up with the state they belong to.
  always_comb begin
    state_next      = state;
    dir_next        = dir;
    last_outer_next = last_outer;
    abort_next      = abort_flag;
    fault_next      = fault;
    done_next       = 1'b0;
    fill_next       = 1'b0;
    drain_next      = 1'b0;

    case (state)
      IDLE: begin
        abort_next = 1'b0;
        if (!fault && (req_outer || req_inner)) begin
          // Contention goes to the side that was not served last.
          dir_next   = (req_outer && req_inner) ? ~last_outer : req_outer;
          state_next = EQ_ENTRY;
        end
      end
      EQ_ENTRY: begin
        if (!served_req) begin
          state_next = IDLE;
        end else if (match) begin
          state_next = OPEN_ENTRY;
        end else if (cnt == EQ_LAST) begin
          fault_next = 1'b1;
          state_next = IDLE;
        end else begin
          fill_next  = below & both_closed;
          drain_next = above & both_closed;
        end
      end
      OPEN_ENTRY: begin
        if (!served_req) begin
          abort_next = 1'b1;
          state_next = CLOSE_ENTRY;
        end else if (entry_closed != PORT_CLOSED) begin
          state_next = ENTER;
        end
      end
      ENTER: begin
        if (gondola_inside) begin
          state_next = CLOSE_ENTRY;
        end else if (cnt == ENTER_LAST || !served_req) begin
          abort_next = 1'b1;
          state_next = CLOSE_ENTRY;
        end
      end
      CLOSE_ENTRY: begin
        if (entry_closed == PORT_CLOSED)
          state_next = abort_flag ? IDLE : EQ_EXIT;
      end
      EQ_EXIT: begin
        // After a timeout the gondola is held here until reset.
        if (!fault) begin
          if (match) begin
            state_next = OPEN_EXIT;
          end else if (cnt == EQ_LAST) begin
            fault_next = 1'b1;
          end else begin
            fill_next  = below & both_closed;
            drain_next = above & both_closed;
          end
        end
      end
      OPEN_EXIT: begin
        if (exit_closed != PORT_CLOSED)
          state_next = EXIT;
      end
      EXIT: begin
        if (!gondola_inside)
          state_next = CLOSE_EXIT;
      end
      CLOSE_EXIT: begin
        if (exit_closed == PORT_CLOSED) begin
          done_next       = 1'b1;
          last_outer_next = dir;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // At most one port is ever commanded open: entry port in the entry
    // phase, exit port in the exit phase.
    entry_open_next = (state_next == OPEN_ENTRY) || (state_next == ENTER);
    exit_open_next  = (state_next == OPEN_EXIT) || (state_next == EXIT);
    outer_cmd_next  = ~((entry_open_next & dir_next) | (exit_open_next & ~dir_next));
    inner_cmd_next  = ~((entry_open_next & ~dir_next) | (exit_open_next & dir_next));

    if (state_next != state)
      cnt_next = '0;
    else if (cnt == CNT_MAX)
      cnt_next = cnt;
    else
      cnt_next = cnt + CW'(1);
  end

`ifdef LOCK_SEQ_STATS_EN
  // Transit count wraps; abort count sticks at its maximum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      transit_count <= 16'd0;
      abort_count   <= 8'd0;
    end else begin
      if (done_next)
        transit_count <= transit_count + 16'd1;
      if (state == CLOSE_ENTRY && state_next == IDLE && abort_count != 8'hFF)
        abort_count <= abort_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer with a simple lock datapath model:
// ports follow their commands half a cycle later and the water moves 2 units
// per cycle while fill or drain is asserted (unless frozen).
module tb_lock_sequencer;
  import lock_pkg::*;

  localparam int TB_TOL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_outer, req_inner;
  logic [7:0] lock_water, outer_water, inner_water;
  logic       outer_closed, inner_closed;
  logic       gondola_inside;
  logic       fill, drain, outer_cmd, inner_cmd;
  logic       grant_outer, grant_inner, depart_ok, transit_done, fault;
`ifdef LOCK_SEQ_STATS_EN
  logic [15:0] transit_count;
  logic [7:0]  abort_count;
`endif

  int   checks = 0;
  int   failures = 0;
  int   done_pulses = 0;
  int   exp_transits = 0;
  logic freeze = 1'b0;
  logic model_last_outer = 1'b0;
  logic exp_grant_q[$];
  logic prev_go = 1'b0, prev_gi = 1'b0, prev_done = 1'b0;

  lock_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .req_outer      (req_outer),
    .req_inner      (req_inner),
    .lock_water     (lock_water),
    .outer_water    (outer_water),
    .inner_water    (inner_water),
    .outer_closed   (outer_closed),
    .inner_closed   (inner_closed),
    .gondola_inside (gondola_inside),
    .fill           (fill),
    .drain          (drain),
    .outer_cmd      (outer_cmd),
    .inner_cmd      (inner_cmd),
    .grant_outer    (grant_outer),
    .grant_inner    (grant_inner),
    .depart_ok      (depart_ok),
    .transit_done   (transit_done),
    .fault          (fault)
`ifdef LOCK_SEQ_STATS_EN
    ,
    .transit_count  (transit_count),
    .abort_count    (abort_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int nearLevel(input logic [7:0] lvl, input logic [7:0] tgt);
    int d;
    d = int'(lvl) - int'(tgt);
    return (d >= -TB_TOL && d <= TB_TOL) ? 1 : 0;
  endfunction

  // Lock datapath model, updated away from the active edge.
  always @(negedge clk) begin
    outer_closed = outer_cmd;
    inner_closed = inner_cmd;
    if (!freeze) begin
      if (fill && lock_water <= 8'd253)
        lock_water = lock_water + 8'd2;
      else if (drain && lock_water >= 8'd2)
        lock_water = lock_water - 8'd2;
    end
  end

  // Grant scoreboard and per-cycle invariants.
  always @(negedge clk) begin
    logic exp_side;
    if ((grant_outer && !prev_go) || (grant_inner && !prev_gi)) begin
      if (exp_grant_q.size() == 0) begin
        checkOutput("grant_unexpected_queue", exp_grant_q.size(), 1);
      end else begin
        exp_side = exp_grant_q.pop_front();
        checkOutput("grant_side_outer", int'(grant_outer), int'(exp_side));
      end
    end
    checkOutput("one_port_closed", int'(outer_cmd | inner_cmd), 1);
    checkOutput("one_grant", int'(grant_outer & grant_inner), 0);
    checkOutput("fill_drain_excl", int'(fill & drain), 0);
    checkOutput("done_single_cycle", int'(transit_done & prev_done), 0);
    if (transit_done) done_pulses++;
    prev_go   = grant_outer;
    prev_gi   = grant_inner;
    prev_done = transit_done;
  end

  task automatic applyStimulus(input logic ro, input logic ri);
    req_outer = ro;
    req_inner = ri;
  endtask

  // Drives one full transit for the side the scoreboard expects.
  task automatic runTransit(input logic side);
    int n;
    n = 0;
    while (!(grant_outer || grant_inner) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tr_grant_wait", int'(n < 300), 1);
    checkOutput("tr_entry_window", nearLevel(lock_water, side ? OUTER_LEVEL : INNER_LEVEL), 1);
    checkOutput("tr_entry_port_open", int'(side ? outer_cmd : inner_cmd), 0);
    gondola_inside = 1'b1;
    @(negedge clk);
    checkOutput("tr_grant_cleared", int'(grant_outer | grant_inner), 0);
    applyStimulus(1'b0, 1'b0);
    n = 0;
    while (!depart_ok && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tr_depart_wait", int'(n < 300), 1);
    checkOutput("tr_exit_window", nearLevel(lock_water, side ? INNER_LEVEL : OUTER_LEVEL), 1);
    checkOutput("tr_exit_port_open", int'(side ? inner_cmd : outer_cmd), 0);
    checkOutput("tr_entry_port_shut", int'(side ? outer_cmd : inner_cmd), 1);
    gondola_inside = 1'b0;
    n = 0;
    while (!transit_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tr_done_wait", int'(n < 20), 1);
    exp_transits++;
    model_last_outer = side;
    @(negedge clk);
    checkOutput("tr_done_pulse_end", int'(transit_done), 0);
    checkOutput("tr_done_count", done_pulses, exp_transits);
`ifdef LOCK_SEQ_STATS_EN
    checkOutput("tr_transit_count", int'(transit_count), exp_transits);
`endif
  endtask

  initial begin
    int n;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    gondola_inside = 1'b0;
    lock_water   = LOCK_RESET_LEVEL;
    outer_water  = OUTER_LEVEL;
    inner_water  = INNER_LEVEL;
    outer_closed = 1'b1;
    inner_closed = 1'b1;

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("rst_outer_cmd", int'(outer_cmd), 1);
    checkOutput("rst_inner_cmd", int'(inner_cmd), 1);
    checkOutput("rst_fill", int'(fill), 0);
    checkOutput("rst_fault", int'(fault), 0);
    checkOutput("rst_depart", int'(depart_ok), 0);
    rst = 1'b1;
    @(negedge clk);

    // Async reset while the outer grant is up.
    exp_grant_q.push_back(1'b1);
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (!grant_outer && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t1_grant_wait", int'(n < 300), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("t1_async_grant", int'(grant_outer), 0);
    checkOutput("t1_async_outer_cmd", int'(outer_cmd), 1);
    checkOutput("t1_async_inner_cmd", int'(inner_cmd), 1);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t1_idle_outer_cmd", int'(outer_cmd), 1);
    checkOutput("t1_idle_inner_cmd", int'(inner_cmd), 1);

    // Simultaneous requests: outer first after reset, then alternate.
    exp_grant_q.push_back(model_last_outer ? 1'b0 : 1'b1);
    applyStimulus(1'b1, 1'b1);
    runTransit(1'b1);
    exp_grant_q.push_back(model_last_outer ? 1'b0 : 1'b1);
    applyStimulus(1'b1, 1'b1);
    runTransit(1'b0);

    // Entry timeout: gondola never arrives.
    exp_grant_q.push_back(1'b1);
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (!grant_outer && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_grant_wait", int'(n < 300), 1);
    n = 0;
    while (grant_outer && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput("t4_grant_cycles", n, 16);
    checkOutput("t4_outer_closing", int'(outer_cmd), 1);
    applyStimulus(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("t4_no_done", done_pulses, exp_transits);
`ifdef LOCK_SEQ_STATS_EN
    checkOutput("t4_abort_count", int'(abort_count), 1);
`endif

    // Request dropped while equalizing: back to idle, port never opened.
    freeze = 1'b1;
    lock_water = 8'd100;
    applyStimulus(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("t6_draining", int'(drain), 1);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_drain_stopped", int'(drain), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t6_inner_kept_closed", int'(inner_cmd), 1);
    end

    // Frozen datapath: equalize timeout sets a sticky fault.
    lock_water = LOCK_RESET_LEVEL;
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (!fault && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_fault_latency_ok", int'(n >= 63 && n <= 67), 1);
    checkOutput("t5_fill_off", int'(fill), 0);
    checkOutput("t5_outer_cmd", int'(outer_cmd), 1);
    repeat (20) @(negedge clk);
    checkOutput("t5_fault_sticky", int'(fault), 1);
    checkOutput("t5_fill_still_off", int'(fill), 0);
    checkOutput("t5_no_grant", int'(grant_outer | grant_inner), 0);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("t5_fault_cleared", int'(fault), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    checkOutput("grant_queue_drained", exp_grant_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
